// File: rtl/spike_pkg.sv
// Shared constants and helpers for the spike detector bank.
// Word addresses of the register map, CTRL bit positions and the saturating absolute value.
package spike_pkg;

  localparam logic [9:0] ADDR_CTRL   = 10'h000;
  localparam logic [9:0] ADDR_REFRAC = 10'h001;
  localparam logic [9:0] ADDR_STATUS = 10'h002;
  localparam logic [9:0] ADDR_CH_EN  = 10'h003;
  localparam logic [9:0] BASE_THRESH = 10'h100;
  localparam logic [9:0] BASE_COUNT  = 10'h200;

  localparam int unsigned CTRL_DET_EN = 32'd0;
  localparam int unsigned CTRL_IRQ_EN = 32'd1;

  // Input is already sign-extended to 16 bits. The unsigned result is exact,
  // so the most negative value maps to 2^(SAMPLE_W-1) instead of wrapping.
  function automatic logic [15:0] abs_sat(input logic [15:0] x);
    return x[15] ? (~x + 16'd1) : x;
  endfunction

endpackage

// File: rtl/spike_channel.sv
// Per-channel detector state: refractory countdown, saturating spike count and spike pulse.
module spike_channel
  import spike_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int REFRAC_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fire,
  input  logic [REFRAC_W-1:0] refrac_len,
  input  logic                cnt_clr,
  output logic                busy,
  output logic [CNT_W-1:0]    count,
  output logic                spike
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [REFRAC_W-1:0] refrac_cnt;
  logic [REFRAC_W-1:0] refrac_load;

  // The count is loaded one edge after the spike sample, so loading N-1 lets
  // the sample presented exactly N cycles after the spike fire again.
  assign refrac_load = (refrac_len == {REFRAC_W{1'b0}}) ? {REFRAC_W{1'b0}}
                                                        : refrac_len - REFRAC_W'(1);
  assign busy = (refrac_cnt != {REFRAC_W{1'b0}});

  // Spike pulse, refractory countdown and saturating count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spike      <= 1'b0;
      refrac_cnt <= {REFRAC_W{1'b0}};
      count      <= {CNT_W{1'b0}};
    end else begin
      spike <= fire;

      if (fire) begin
        refrac_cnt <= refrac_load;
      end else if (busy) begin
        refrac_cnt <= refrac_cnt - REFRAC_W'(1);
      end else begin
        refrac_cnt <= refrac_cnt;
      end

      if (cnt_clr && fire) begin
        count <= CNT_W'(1);
      end else if (cnt_clr) begin
        count <= {CNT_W{1'b0}};
      end else if (fire && (count != CNT_MAX)) begin
        count <= count + CNT_W'(1);
      end else begin
        count <= count;
      end
    end
  end

endmodule

// File: rtl/spike_detector_bank.sv
// Multi-channel threshold spike detector with a core-facing register file and level interrupt.
// The top holds the register file, decode, readback mux, STATUS and irq.
module spike_detector_bank
  import spike_pkg::*;
#(
  parameter int NUM_CH   = 16,
  parameter int SAMPLE_W = 16,
  parameter int ADDR_W   = 10,
  parameter int CNT_W    = 16,
  parameter int REFRAC_W = 8,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [CH_W-1:0]     sample_ch,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic                risc_v_read,
  input  logic                risc_v_write,
  input  logic [ADDR_W-1:0]   risc_v_addr,
  input  logic [31:0]         risc_v_data_in,
  output logic [15:0]         risc_v_data_out,
  output logic                risc_v_rvalid,
  output logic [NUM_CH-1:0]   spike_detected,
  output logic                irq
);

  logic                det_en;
  logic                irq_en;
  logic [REFRAC_W-1:0] refrac;
  logic [NUM_CH-1:0]   ch_en;
  logic [NUM_CH-1:0]   status;
  logic [SAMPLE_W-1:0] thresh [NUM_CH];
  logic [CNT_W-1:0]    count  [NUM_CH];

  logic [NUM_CH-1:0]   fire;
  logic [NUM_CH-1:0]   busy;
  logic [NUM_CH-1:0]   w1c;
  logic [NUM_CH-1:0]   wr_thresh;
  logic [NUM_CH-1:0]   wr_count;
  logic                wr_ctrl;
  logic                wr_refrac;
  logic                wr_status;
  logic                wr_ch_en;
  logic [15:0]         sample_ext;
  logic [15:0]         mag;
  logic [15:0]         rd_mux;
  logic                unused_data;

  assign unused_data = &{1'b0, risc_v_data_in};

  assign sample_ext = 16'($signed(sample_data));
  assign mag        = abs_sat(sample_ext);

  assign wr_ctrl   = risc_v_write && (risc_v_addr == ADDR_W'(ADDR_CTRL));
  assign wr_refrac = risc_v_write && (risc_v_addr == ADDR_W'(ADDR_REFRAC));
  assign wr_status = risc_v_write && (risc_v_addr == ADDR_W'(ADDR_STATUS));
  assign wr_ch_en  = risc_v_write && (risc_v_addr == ADDR_W'(ADDR_CH_EN));
  assign w1c       = wr_status ? risc_v_data_in[NUM_CH-1:0] : {NUM_CH{1'b0}};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign wr_thresh[g] = risc_v_write &&
                          (risc_v_addr == ADDR_W'(BASE_THRESH) + ADDR_W'(g));
    assign wr_count[g]  = risc_v_write &&
                          (risc_v_addr == ADDR_W'(BASE_COUNT) + ADDR_W'(g));
    // Uses the pre-write THRESH/CH_EN/CTRL values, so same-cycle writes see the old setting.
    assign fire[g] = sample_valid && det_en && ch_en[g] && !busy[g] &&
                     (sample_ch == CH_W'(g)) && (mag > 16'(thresh[g]));

    spike_channel #(
      .CNT_W   (CNT_W),
      .REFRAC_W(REFRAC_W)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .fire      (fire[g]),
      .refrac_len(refrac),
      .cnt_clr   (wr_count[g]),
      .busy      (busy[g]),
      .count     (count[g]),
      .spike     (spike_detected[g])
    );
  end

  // Readback mux; unmapped addresses read as zero.
  always_comb begin
    rd_mux = 16'h0000;
    if (risc_v_addr == ADDR_W'(ADDR_CTRL)) begin
      rd_mux[CTRL_DET_EN] = det_en;
      rd_mux[CTRL_IRQ_EN] = irq_en;
    end else if (risc_v_addr == ADDR_W'(ADDR_REFRAC)) begin
      rd_mux = 16'(refrac);
    end else if (risc_v_addr == ADDR_W'(ADDR_STATUS)) begin
      rd_mux = 16'(status);
    end else if (risc_v_addr == ADDR_W'(ADDR_CH_EN)) begin
      rd_mux = 16'(ch_en);
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (risc_v_addr == ADDR_W'(BASE_THRESH) + ADDR_W'(i)) begin
          rd_mux = 16'(thresh[i]);
        end else if (risc_v_addr == ADDR_W'(BASE_COUNT) + ADDR_W'(i)) begin
          rd_mux = 16'(count[i]);
        end else begin
          rd_mux = rd_mux;
        end
      end
    end
  end

  // Configuration registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      det_en <= 1'b0;
      irq_en <= 1'b0;
      refrac <= {REFRAC_W{1'b0}};
      ch_en  <= {NUM_CH{1'b1}};
      for (int i = 0; i < NUM_CH; i++) begin
        thresh[i] <= {SAMPLE_W{1'b1}};
      end
    end else begin
      if (wr_ctrl) begin
        det_en <= risc_v_data_in[CTRL_DET_EN];
        irq_en <= risc_v_data_in[CTRL_IRQ_EN];
      end
      if (wr_refrac) begin
        refrac <= risc_v_data_in[REFRAC_W-1:0];
      end
      if (wr_ch_en) begin
        ch_en <= risc_v_data_in[NUM_CH-1:0];
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_thresh[i]) begin
          thresh[i] <= risc_v_data_in[SAMPLE_W-1:0];
        end
      end
    end
  end

  // Sticky status (a new spike beats W1C), interrupt and read response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status          <= {NUM_CH{1'b0}};
      irq             <= 1'b0;
      risc_v_rvalid   <= 1'b0;
      risc_v_data_out <= 16'h0000;
    end else begin
      status        <= (status & ~w1c) | fire;
      irq           <= irq_en && (status != {NUM_CH{1'b0}});
      risc_v_rvalid <= risc_v_read;
      if (risc_v_read) begin
        risc_v_data_out <= rd_mux;
      end
    end
  end

endmodule
